// File: rtl/alu_out_stage_if.sv
// rtl/alu_out_stage_if.sv - result/flags stream bundle between ALU, output stage and consumer
interface alu_out_stage_if #(parameter int N = 4);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_result;
    logic [3:0]   in_select;
    logic         in_carry;
    logic         in_overflow;
    logic         in_div_zero;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic [3:0]   out_flags;

    modport master (
        output in_valid, in_result, in_select, in_carry, in_overflow, in_div_zero, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_result, in_select, in_carry, in_overflow, in_div_zero, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/alu_out_stage.sv
// rtl/alu_out_stage.sv - 2-entry result/flags FIFO with sticky error and pop counter
// Define ALU_OUT_COUNT_EN to build the op_count pop counter; otherwise op_count is tied to 0.
module alu_out_stage #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_out_stage_if.slave bus,
    input  logic           err_clr,
    output logic           out_err,
    output logic [7:0]     op_count
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] head_res_q, head_res_d;
    logic [3:0]   head_flg_q, head_flg_d;
    logic [N-1:0] tail_res_q, tail_res_d;
    logic [3:0]   tail_flg_q, tail_flg_d;
    logic         err_q, err_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic         push, pop;
    logic         flag_c, flag_v, bad_op;
    logic [3:0]   new_flags;

    always_comb begin
        push   = bus.in_valid && in_ready_q;
        pop    = out_valid_q && bus.out_ready;
        flag_c = (bus.in_select == 4'd0 || bus.in_select == 4'd1 ||
                  bus.in_select == 4'd5 || bus.in_select == 4'd7) ? bus.in_carry : 1'b0;
        flag_v = (bus.in_select == 4'd0 || bus.in_select == 4'd1 ||
                  bus.in_select == 4'd8) ? bus.in_overflow : 1'b0;
        bad_op = (bus.in_select == 4'd6) || (bus.in_select >= 4'd11) ||
                 ((bus.in_select == 4'd9 || bus.in_select == 4'd10) && bus.in_div_zero);
        new_flags = {bus.in_result[N-1], (bus.in_result == '0), flag_c, flag_v};
    end

    always_comb begin
        state_d    = state_q;
        head_res_d = head_res_q;
        head_flg_d = head_flg_q;
        tail_res_d = tail_res_q;
        tail_flg_d = tail_flg_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_res_d = bus.in_result;
                    head_flg_d = new_flags;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_res_d = bus.in_result;
                    head_flg_d = new_flags;
                end else if (push) begin
                    tail_res_d = bus.in_result;
                    tail_flg_d = new_flags;
                    state_d    = FULL;
                end else if (pop) begin
                    // Outputs read 0 whenever nothing is held.
                    head_res_d = '0;
                    head_flg_d = '0;
                    state_d    = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_res_d = tail_res_q;
                    head_flg_d = tail_flg_q;
                    tail_res_d = '0;
                    tail_flg_d = '0;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
        // A new error on this push outranks a clear request in the same cycle.
        if (push && bad_op)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
        else
            err_d = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_res_q  <= '0;
            head_flg_q  <= '0;
            tail_res_q  <= '0;
            tail_flg_q  <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_res_q  <= head_res_d;
            head_flg_q  <= head_flg_d;
            tail_res_q  <= tail_res_d;
            tail_flg_q  <= tail_flg_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = head_res_q;
    assign bus.out_flags  = head_flg_q;
    assign out_err        = err_q;

`ifdef ALU_OUT_COUNT_EN
    logic [7:0] count_q, count_d;

    always_comb count_d = pop ? count_q + 8'd1 : count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= 8'd0;
        else
            count_q <= count_d;
    end

    assign op_count = count_q;
`else
    assign op_count = 8'd0;
`endif
endmodule

// File: tb/tb_alu_out_stage.sv
// tb/tb_alu_out_stage.sv - directed vector bench for alu_out_stage (N=4)
module tb_alu_out_stage;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       err_clr;
    logic       out_err;
    logic [7:0] op_count;
    int         checks = 0;
    int         errors = 0;

`ifdef ALU_OUT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    alu_out_stage_if #(.N(4)) bus ();

    alu_out_stage #(.N(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .err_clr  (err_clr),
        .out_err  (out_err),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] result;
        logic [3:0] sel;
        logic       carry;
        logic       ovf;
        logic       dz;
        logic [3:0] exp_flags;
        logic       exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] r, input logic [3:0] s);
        bus.in_valid    = 1'b1;
        bus.in_result   = r;
        bus.in_select   = s;
        bus.in_carry    = 1'b0;
        bus.in_overflow = 1'b0;
        bus.in_div_zero = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 4'd0,  1'b1, 1'b0, 1'b0, 4'b0110, 1'b0};
        vecs[1]  = '{4'b1000, 4'd6,  1'b1, 1'b1, 1'b0, 4'b1000, 1'b1};
        vecs[2]  = '{4'b0111, 4'd1,  1'b0, 1'b1, 1'b0, 4'b0001, 1'b0};
        vecs[3]  = '{4'b1111, 4'd5,  1'b1, 1'b1, 1'b0, 4'b1010, 1'b0};
        vecs[4]  = '{4'b0011, 4'd8,  1'b1, 1'b1, 1'b0, 4'b0001, 1'b0};
        vecs[5]  = '{4'b0000, 4'd9,  1'b0, 1'b0, 1'b1, 4'b0100, 1'b1};
        vecs[6]  = '{4'b0101, 4'd10, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0};
        vecs[7]  = '{4'b1100, 4'd7,  1'b1, 1'b1, 1'b0, 4'b1010, 1'b0};
        vecs[8]  = '{4'b0010, 4'd15, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1};
        vecs[9]  = '{4'b0000, 4'd11, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1};
        vecs[10] = '{4'b1001, 4'd2,  1'b1, 1'b1, 1'b1, 4'b1000, 1'b0};

        rst_n = 1'b0;
        err_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_result = '0;
        bus.in_select = '0;
        bus.in_carry = 1'b0;
        bus.in_overflow = 1'b0;
        bus.in_div_zero = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_flags", bus.out_flags, 0);
        check("rst_out_err", out_err, 0);
        check("rst_op_count", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            bus.in_valid    = 1'b1;
            bus.in_result   = vecs[i].result;
            bus.in_select   = vecs[i].sel;
            bus.in_carry    = vecs[i].carry;
            bus.in_overflow = vecs[i].ovf;
            bus.in_div_zero = vecs[i].dz;
            step();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            check($sformatf("vec%0d_result", i), bus.out_result, vecs[i].result);
            check($sformatf("vec%0d_flags", i), bus.out_flags, vecs[i].exp_flags);
            check($sformatf("vec%0d_err", i), out_err, vecs[i].exp_err);
            err_clr = 1'b1;
            bus.out_ready = 1'b1;
            step();
            err_clr = 1'b0;
            bus.out_ready = 1'b0;
            check($sformatf("vec%0d_drained", i), bus.out_valid, 0);
            check($sformatf("vec%0d_err_clr", i), out_err, 0);
            check($sformatf("vec%0d_empty_result", i), bus.out_result, 0);
        end

        // Backpressure: three offers with the consumer stalled, two accepted.
        offer(4'd3, 4'd2);
        step();
        check("bp_ready_after1", bus.in_ready, 1);
        offer(4'd5, 4'd2);
        step();
        check("bp_ready_after2", bus.in_ready, 0);
        offer(4'd9, 4'd2);
        step();
        check("bp_ready_after3", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        check("bp_head0", bus.out_result, 3);
        bus.out_ready = 1'b1;
        step();
        check("bp_head1", bus.out_result, 5);
        check("bp_ready_one", bus.in_ready, 1);
        step();
        check("bp_empty", bus.out_valid, 0);
        check("bp_empty_result", bus.out_result, 0);
        bus.out_ready = 1'b0;

        // FULL with pop and offer together: pop only, new entry refused.
        offer(4'd1, 4'd2);
        step();
        offer(4'd2, 4'd2);
        step();
        check("full_ready", bus.in_ready, 0);
        offer(4'd7, 4'd2);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("fullpop_ready", bus.in_ready, 1);
        check("fullpop_valid", bus.out_valid, 1);
        check("fullpop_head", bus.out_result, 2);
        step();
        check("fullpop_nopush", bus.out_result, 2);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("fullpop_empty", bus.out_valid, 0);

        // Error set in the same cycle as err_clr keeps out_err high.
        offer(4'd4, 4'd12);
        step();
        check("setclr_err1", out_err, 1);
        offer(4'd6, 4'd13);
        err_clr = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("setclr_err_wins", out_err, 1);
        check("setclr_pushpop_head", bus.out_result, 6);
        check("setclr_pushpop_valid", bus.out_valid, 1);
        step();
        err_clr = 1'b0;
        bus.out_ready = 1'b0;
        check("setclr_err0", out_err, 0);
        check("setclr_empty", bus.out_valid, 0);

        // Asynchronous reset while FULL.
        offer(4'd8, 4'd6);
        step();
        offer(4'd9, 4'd2);
        step();
        bus.in_valid = 1'b0;
        check("rstfull_full", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstfull_valid", bus.out_valid, 0);
        check("rstfull_ready", bus.in_ready, 1);
        check("rstfull_result", bus.out_result, 0);
        check("rstfull_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rstfull_still_empty", bus.out_valid, 0);

        // Streaming push+pop each cycle for 256 pops.
        offer(4'd1, 4'd0);
        bus.out_ready = 1'b1;
        step();
        check("cnt_before_pop", op_count, 0);
        step();
        check("cnt_1", op_count, CNT_EN ? 32'd1 : 32'd0);
        repeat (254) step();
        check("cnt_255", op_count, CNT_EN ? 32'd255 : 32'd0);
        step();
        check("cnt_wrap", op_count, 0);
        check("cnt_stream_valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        check("cnt_257", op_count, CNT_EN ? 32'd1 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_out_stage.md
ALU_OUT_STAGE -- requirements
Module: alu_out_stage

Interface
REQ-001 The block SHALL have a parameter N, default 4: datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream offers a result.
REQ-005 The block SHALL have port in_ready, output, 1 bit: stage can accept an entry.
REQ-006 The block SHALL have port in_result, input, N bits: selected ALU result.
REQ-007 The block SHALL have port in_select, input, 4 bits: opcode that produced in_result.
REQ-008 The block SHALL have port in_carry, input, 1 bit: carry/borrow/shift-out from the ALU.
REQ-009 The block SHALL have port in_overflow, input, 1 bit: signed overflow from the ALU.
REQ-010 The block SHALL have port in_div_zero, input, 1 bit: divisor was zero.
REQ-011 The block SHALL have port out_valid, output, 1 bit: head entry present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer takes the head entry.
REQ-013 The block SHALL have port out_result, output, N bits: head result.
REQ-014 The block SHALL have port out_flags, output, 4 bits: head flags {N,Z,C,V}, bit 3 = N.
REQ-015 The block SHALL have port out_err, output, 1 bit: sticky error.
REQ-016 The block SHALL have port err_clr, input, 1 bit: synchronous clear of out_err.
REQ-017 The block SHALL have port op_count, output, 8 bits: count of entries delivered.

Function
REQ-018 The block SHALL store entries in a 2-entry FIFO; entry = result, flags.
REQ-019 The FIFO SHALL use occupancy states EMPTY, ONE and FULL.
- Push only: EMPTY->ONE, ONE->FULL.
- Pop only: FULL->ONE, ONE->EMPTY.
- Push+pop in ONE: stay in ONE.
REQ-020 Push SHALL occur on in_valid && in_ready; pop SHALL occur on out_valid && out_ready.
REQ-021 in_ready SHALL be 1 exactly when the state is not FULL, registered only, with no combinational path from out_ready; in FULL a simultaneous pop does not admit a push.
REQ-022 out_valid SHALL be 1 exactly when the state is not EMPTY; out_result/out_flags SHALL show the oldest entry and be 0 when EMPTY.
REQ-023 Latency SHALL be one cycle: an entry pushed at edge k is visible at the outputs after edge k.
REQ-024 Z SHALL equal (in_result == 0); N SHALL equal in_result[N-1].
REQ-025 C SHALL equal in_carry for select 0, 1, 5 and 7, else 0.
REQ-026 V SHALL equal in_overflow for select 0, 1 and 8, else 0.
REQ-027 out_err SHALL set on a push when:
- in_select is 6 or 11-15 (illegal), or
- in_select is 9 or 10 with in_div_zero=1.
REQ-028 The entry of an illegal push SHALL still be stored, with flags computed per REQ-024..026.
REQ-029 err_clr SHALL clear out_err at the next edge; a simultaneous set SHALL win over err_clr.
REQ-030 op_count SHALL increment on each pop and wrap 255->0.

Reset
REQ-031 rst_n=0 SHALL immediately force: state EMPTY, in_ready=1, out_valid=0, out_result=0, out_flags=0, out_err=0, op_count=0.
REQ-032 Reset mid-operation SHALL discard all stored entries; no push or pop SHALL occur while rst_n=0.

Configuration
REQ-033 With macro ALU_OUT_COUNT_EN defined, op_count SHALL behave per REQ-030; without it, op_count SHALL be tied to 0 and the counter SHALL not be built.

Verification
REQ-034 The bench SHALL cover these scenarios (N=4):
- Add: push result 4'b0000, select 0, carry=1 -> next cycle out_valid=1, out_flags=4'b0110.
- Backpressure: out_ready=0, push 3 times -> 2 accepted; in_ready=0 after the 2nd; entries popped in order.
- FULL with pop and in_valid in the same cycle -> one pop, no push, state ONE, in_ready=1.
- Divide: select 9, in_div_zero=1 -> out_err=1; err_clr with no new error -> out_err=0 next cycle.
- Illegal select 6, result 4'b1000 -> out_err=1, out_flags=4'b1000.
- rst_n low while FULL -> out_valid=0 at once; with ALU_OUT_COUNT_EN, 256 pops -> op_count=0.
